// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU among NUM_REQ requesters.
// Defining ALU_ARBITER_PERF_EN adds per-requester grant and wait counters.
module alu_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*4-1:0]  req_sel_i,
    input  logic [NUM_REQ*32-1:0] req_op1_i,
    input  logic [NUM_REQ*32-1:0] req_op2_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [31:0]           rsp_result_o,
    output logic [3:0]            alu_sel_o,
    output logic [31:0]           alu_op1_o,
    output logic [31:0]           alu_op2_o,
    input  logic [31:0]           alu_result_i,
`ifdef ALU_ARBITER_PERF_EN
    output logic [NUM_REQ*32-1:0] grant_cnt_o,
    output logic [NUM_REQ*32-1:0] wait_cnt_o,
`endif
    output logic                  busy_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic [3:0]           sel_q;
    logic [31:0]          op1_q;
    logic [31:0]          op2_q;
    logic [31:0]          result_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 busy_q;
    logic                 grant_found_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [NUM_REQ-1:0]   grant_oh_s;
    logic                 rsp_done_s;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            oh[k] = (idx == IDX_W'(k));
        end
        return oh;
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand          = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found_s && req_valid_i[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Ready is gated by reset so every output reads zero while rst_ni is low.
    always_comb begin
        grant_oh_s = '0;
        if (rst_ni && (state_q == IDLE) && grant_found_s) begin
            grant_oh_s = idx_to_onehot(grant_idx_s);
        end else begin
            grant_oh_s = '0;
        end
        rsp_done_s = (state_q == RESP) && rsp_ready_i[grant_idx_q];
    end

    // Transaction FSM with operand, result and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            sel_q       <= 4'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            result_q    <= 32'd0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found_s) begin
                        sel_q       <= req_sel_i[{grant_idx_s, 2'b00} +: 4];
                        op1_q       <= req_op1_i[{grant_idx_s, 5'b00000} +: 32];
                        op2_q       <= req_op2_i[{grant_idx_s, 5'b00000} +: 32];
                        grant_idx_q <= grant_idx_s;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result_i;
                    rsp_valid_q <= idx_to_onehot(grant_idx_q);
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_done_s) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    logic [NUM_REQ*32-1:0] grant_cnt_q;
    logic [NUM_REQ*32-1:0] wait_cnt_q;

    // Per-requester grant and stall counters, wrapping modulo 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant_oh_s[k]) begin
                    grant_cnt_q[k*32 +: 32] <= grant_cnt_q[k*32 +: 32] + 32'd1;
                end
                if (req_valid_i[k] && !grant_oh_s[k]) begin
                    wait_cnt_q[k*32 +: 32] <= wait_cnt_q[k*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
`endif

    assign req_ready_o  = grant_oh_s;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = result_q;
    assign alu_sel_o    = sel_q;
    assign alu_op1_o    = op1_q;
    assign alu_op2_o    = op2_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stub and a response scoreboard.
module tb_alu_arbiter;
    localparam int NR = 3;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_CLZ  = 4'd10;
    localparam logic [3:0] ALU_CPOP = 4'd12;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [NR-1:0]  req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [NR*4-1:0]  req_sel_i;
    logic [NR*32-1:0] req_op1_i, req_op2_i;
    logic [31:0]    rsp_result_o, alu_op1_o, alu_op2_o, alu_result_i;
    logic [3:0]     alu_sel_o;
    logic           busy_o;
`ifdef ALU_ARBITER_PERF_EN
    logic [NR*32-1:0] grant_cnt_o, wait_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] sbq[$];

    alu_arbiter #(.NUM_REQ(NR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_sel_i(req_sel_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .alu_sel_o(alu_sel_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
        .alu_result_i(alu_result_i),
`ifdef ALU_ARBITER_PERF_EN
        .grant_cnt_o(grant_cnt_o), .wait_cnt_o(wait_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (s)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_XOR: r = a ^ b;
            ALU_CLZ: begin
                r = 32'd32;
                for (int i = 0; i < 32; i++) if (a[i]) r = 32'(31 - i);
            end
            ALU_CPOP: for (int i = 0; i < 32; i++) r = r + 32'(a[i]);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb alu_result_i = ref_alu(alu_sel_o, alu_op1_o, alu_op2_o);

    function automatic logic [NR-1:0] idx2oh(input logic [3:0] i);
        return NR'(1) << i;
    endfunction

    function automatic logic [3:0] oh2idx(input logic [NR-1:0] oh);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < NR; k++) if (oh[k]) r = 4'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        req_sel_i[k*4 +: 4]  = s;
        req_op1_i[k*32 +: 32] = a;
        req_op2_i[k*32 +: 32] = b;
    endtask

    task automatic sb_push(input logic [3:0] idx, input logic [31:0] res);
        sbq.push_back({idx, res});
    endtask

    task automatic sb_check(input string tag);
        logic [35:0] e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: response with empty scoreboard, rsp_valid_o=%b", tag, rsp_valid_o);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(idx2oh(e[35:32])));
            chk({tag, "_result"}, 64'(rsp_result_o), 64'(e[31:0]));
        end
    endtask

    initial begin
        int ngr;
        int gcyc[4];
        logic [3:0] gord[4];
        logic [3:0] gi;

        rst_ni      = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_sel_i   = '0;
        req_op1_i   = '0;
        req_op2_i   = '0;
        #1;

        // Reset held with random inputs: all outputs zero.
        for (int i = 0; i < 4; i++) begin
            req_valid_i = NR'($urandom);
            rsp_ready_i = NR'($urandom);
            req_sel_i   = 12'($urandom);
            req_op1_i   = {$urandom, $urandom, $urandom};
            req_op2_i   = {$urandom, $urandom, $urandom};
            @(negedge clk_i);
            chk("rst_req_ready", 64'(req_ready_o), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
            chk("rst_rsp_result", 64'(rsp_result_o), 64'(0));
            chk("rst_alu_sel", 64'(alu_sel_o), 64'(0));
            chk("rst_alu_op1", 64'(alu_op1_o), 64'(0));
            chk("rst_alu_op2", 64'(alu_op2_o), 64'(0));
            chk("rst_busy", 64'(busy_o), 64'(0));
            step();
        end
        req_valid_i = '0;
        rsp_ready_i = '0;
        rst_ni      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("idle_busy", 64'(busy_o), 64'(0));
            chk("idle_ready", 64'(req_ready_o), 64'(0));
            step();
        end

        // Single op: req 1 ADD 5 + 7.
        set_req(1, ALU_ADD, 32'h0000_0005, 32'h0000_0007);
        req_valid_i = 3'b010;
        @(negedge clk_i);
        chk("single_ready", 64'(req_ready_o), 64'(3'b010));
        sb_push(4'd1, 32'h0000_000C);
        step();
        req_valid_i = 3'b000;
        @(negedge clk_i);
        chk("single_op1", 64'(alu_op1_o), 64'(32'h5));
        chk("single_op2", 64'(alu_op2_o), 64'(32'h7));
        chk("single_sel", 64'(alu_sel_o), 64'(ALU_ADD));
        chk("single_exec_busy", 64'(busy_o), 64'(1));
        chk("single_exec_rsp", 64'(rsp_valid_o), 64'(0));
        step();
        @(negedge clk_i);
        sb_check("single_rsp");
        rsp_ready_i = 3'b010;
        step();
        rsp_ready_i = 3'b000;
        @(negedge clk_i);
        chk("single_done_busy", 64'(busy_o), 64'(0));
        chk("single_done_rsp", 64'(rsp_valid_o), 64'(0));
        step();

        // Round-robin from a fresh pointer with all requesters valid.
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        set_req(1, ALU_SUB, 32'd100, 32'd1);
        set_req(2, ALU_CPOP, 32'h0000_F0F0, 32'd0);
        rsp_ready_i = 3'b111;
        req_valid_i = 3'b111;
        ngr = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk_i);
            if (req_ready_o != '0) begin
                gi = oh2idx(req_ready_o);
                if (ngr < 4) begin
                    gord[ngr] = gi;
                    gcyc[ngr] = cyc;
                end
                ngr++;
                sb_push(gi, ref_alu(req_sel_i[gi*4 +: 4], req_op1_i[gi*32 +: 32], req_op2_i[gi*32 +: 32]));
            end
            if (rsp_valid_o != '0) sb_check("rr_rsp");
            step();
        end
        req_valid_i = 3'b000;
        chk("rr_num_grants", 64'(ngr), 64'(4));
        if (ngr >= 4) begin
            chk("rr_order0", 64'(gord[0]), 64'(0));
            chk("rr_order1", 64'(gord[1]), 64'(1));
            chk("rr_order2", 64'(gord[2]), 64'(2));
            chk("rr_order3", 64'(gord[3]), 64'(0));
            chk("rr_first_cycle", 64'(gcyc[0]), 64'(0));
            for (int i = 0; i < 3; i++) chk("rr_spacing", 64'(gcyc[i+1] - gcyc[i]), 64'(3));
        end
        chk("rr_sb_drained", 64'(sbq.size()), 64'(0));

        // Backpressure: req 2 SUB 0-1 held in RESP while req 0 waits.
        set_req(2, ALU_SUB, 32'd0, 32'd1);
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        req_valid_i = 3'b101;
        rsp_ready_i = 3'b000;
        @(negedge clk_i);
        chk("bp_ready", 64'(req_ready_o), 64'(3'b100));
        sb_push(4'd2, 32'hFFFF_FFFF);
        step();
        req_valid_i = 3'b001;
        @(negedge clk_i);
        chk("bp_exec_ready", 64'(req_ready_o), 64'(0));
        step();
        for (int i = 0; i < 5; i++) begin
            rsp_ready_i = (i % 2 == 1) ? 3'b001 : 3'b000;
            @(negedge clk_i);
            chk("bp_hold_valid", 64'(rsp_valid_o), 64'(3'b100));
            chk("bp_hold_result", 64'(rsp_result_o), 64'(32'hFFFF_FFFF));
            chk("bp_hold_ready", 64'(req_ready_o), 64'(0));
            chk("bp_hold_busy", 64'(busy_o), 64'(1));
            step();
        end
        set_req(2, ALU_CLZ, 32'h0000_0001, 32'd0);
        req_valid_i = 3'b101;
        rsp_ready_i = 3'b100;
        @(negedge clk_i);
        chk("bp_release_ready", 64'(req_ready_o), 64'(0));
        sb_check("bp_rsp");
        step();

        // Pointer wrapped to 0: req 0 wins over req 2, then req 2 CLZ.
        rsp_ready_i = 3'b111;
        @(negedge clk_i);
        chk("wrap_ready0", 64'(req_ready_o), 64'(3'b001));
        sb_push(4'd0, 32'd2);
        step();
        req_valid_i = 3'b100;
        @(negedge clk_i);
        chk("wrap_exec_ready", 64'(req_ready_o), 64'(0));
        step();
        @(negedge clk_i);
        sb_check("wrap_rsp0");
        step();
        @(negedge clk_i);
        chk("wrap_ready2", 64'(req_ready_o), 64'(3'b100));
        sb_push(4'd2, 32'd31);
        step();
        req_valid_i = 3'b000;
        step();
        @(negedge clk_i);
        sb_check("clz_rsp");
        step();

        // Reset mid-op: advance pointer to 1, then abort req 1 in EXEC.
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        req_valid_i = 3'b001;
        @(negedge clk_i);
        chk("pre_rst_ready0", 64'(req_ready_o), 64'(3'b001));
        sb_push(4'd0, 32'd7);
        step();
        req_valid_i = 3'b000;
        step();
        @(negedge clk_i);
        sb_check("pre_rst_rsp");
        step();
        set_req(1, ALU_XOR, 32'h0000_00FF, 32'h0000_000F);
        req_valid_i = 3'b010;
        @(negedge clk_i);
        chk("pre_rst_ready1", 64'(req_ready_o), 64'(3'b010));
        step();
        req_valid_i = 3'b000;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_rsp", 64'(rsp_valid_o), 64'(0));
        chk("midrst_op1", 64'(alu_op1_o), 64'(0));
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("postrst_no_rsp", 64'(rsp_valid_o), 64'(0));
            chk("postrst_busy", 64'(busy_o), 64'(0));
            step();
        end
        set_req(0, ALU_ADD, 32'd2, 32'd2);
        req_valid_i = 3'b011;
        @(negedge clk_i);
        chk("postrst_ready", 64'(req_ready_o), 64'(3'b001));
        sb_push(4'd0, 32'd4);
        step();
        req_valid_i = 3'b000;
        step();
        @(negedge clk_i);
        sb_check("postrst_rsp");
        step();

        chk("final_sb_empty", 64'(sbq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
